mem_scan_master: RTL
====================

# mem_scan_master

Bus-initiator pattern-count engine on the data-memory side of the processor. It drives the data-memory port (`Address`, `Write_data`, `MemRead`, `MemWrite`) and consumes its combinational `Read_data`. It loads a word pattern into a local buffer, then scans a word string in memory and counts every occurrence of the pattern, including overlapping ones. When the scan finishes, it writes the count to the memory-mapped BCD register.

## Interface
Parameters:
- `PAT_MAX`, 16: pattern buffer depth in words; legal `pat_len` is 1..PAT_MAX.
- `RESULT_ADDR`, 32'h40000010: BCD register address that receives the result.
- `LED_ADDR`, 32'h4000000C: LED register address (used only with `SCAN_LED_EN`).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: sampled in IDLE only; ignored while busy.
- `str_base` in 32: byte address of string word 0 (word-aligned).
- `str_len` in 16: string length in words.
- `pat_base` in 32: byte address of pattern word 0.
- `pat_len` in 8: pattern length in words.
- `Address` out 32: bus address.
- `Write_data` out 32: bus write data.
- `MemRead` out 1: bus read strobe.
- `MemWrite` out 1: bus write strobe.
- `Read_data` in 32: read data, valid in the same cycle as `Address`/`MemRead`.
- `busy` out 1: high from the cycle after start acceptance through DONE.
- `done` out 1: one-cycle pulse.
- `match_count` out 16: result; holds until the next accepted start.

## Operation
- FSM states: IDLE, LOAD, SCAN, WR_RES, WR_LED (macro only), DONE. `i` = string offset, `j` = pattern index.
- IDLE
  - Bus outputs are all 0.
  - On `start`, latch all inputs, clear count, set `i=j=0`, then go to LOAD.
  - If `pat_len==0`, `pat_len>PAT_MAX` or `pat_len>str_len`, go to WR_RES instead, with count 0.
- LOAD
  - Drive `Address=pat_base+4*j`, `MemRead=1`.
  - At each edge, `pat_buf[j]<=Read_data`.
  - After `j==pat_len-1`, go to SCAN with `j=0`.
- SCAN
  - Drive `Address=str_base+4*(i+j)`, `MemRead=1`.
  - Compare full 32-bit `Read_data` with `pat_buf[j]`:
    - Mismatch: advance.
    - Match and `j==pat_len-1`: count+1, then advance.
    - Match otherwise: `j+1`.
  - Advance means `j=0`; then if `i==str_len-pat_len` go to WR_RES, else `i+1`.
- WR_RES
  - Drive `Address=RESULT_ADDR`, `Write_data={16'b0,count}`, `MemWrite=1` for exactly one cycle.
- DONE
  - `done=1` for one cycle, `match_count` updated, then return to IDLE.
- `MemRead` and `MemWrite` are never high together. Bus outputs are combinational decodes of registered state and counters.
- Arithmetic rules:
  - Address arithmetic wraps modulo 2^32.
  - `i+j` is computed in 17 bits before the ×4.
  - Count saturates at 16'hFFFF.
- Reset, including mid-operation:
  - All registers clear; state becomes IDLE.
  - `busy`, `done` and `match_count` go to 0; bus outputs go to 0 immediately.
  - No partial result write occurs.

## Timing
- Reset values: every output is 0.
- One bus access per cycle; zero wait states; no stall input.
- With start accepted at edge E0, cycles are counted after E0:
  - LOAD: `pat_len` cycles.
  - SCAN: one cycle per compared word (mismatch exits a position early).
  - WR_RES: 1 cycle.
  - WR_LED: 1 cycle (macro only).
  - DONE: 1 cycle.
- Worst case from start to done: `pat_len + (str_len-pat_len+1)*pat_len + 2` cycles (+1 with macro).
- Illegal-length start: WR_RES is the first cycle after E0 and DONE the second.
- `start` high during DONE is ignored. `start` is accepted only in IDLE, which is the cycle after DONE at the earliest.

## Configuration
- `SCAN_LED_EN` defined:
  - WR_RES is followed by WR_LED.
  - WR_LED drives `Address=LED_ADDR`, `Write_data={16'b0,count}`, `MemWrite=1` for one cycle.
  - Total latency is +1 cycle.
- `SCAN_LED_EN` undefined: WR_RES goes directly to DONE, and `LED_ADDR` is never driven.

## Test plan
- Memory image with "Linux is Not Unix is Unix is Unix" (one char per word at word 0) and "Unix" at word 256. Start with `str_base=0`, `str_len=33`, `pat_base=32'h400`, `pat_len=4` -> count 3, one write of 32'h3 to 32'h40000010, `done` pulses once.
- String "aaaa" (`str_len=4`), pattern "aa" (`pat_len=2`) -> count 3 (overlap counted).
- `str_len=1`, `pat_len=1`, equal words -> LOAD, SCAN, WR_RES, DONE; `done` high in the 4th cycle after E0; count 1.
- `pat_len=0`, then `pat_len=17` -> no reads at all; write 0 to `RESULT_ADDR`; `done` in the 2nd cycle after E0.
- Reset asserted during SCAN -> all outputs 0 asynchronously, no `MemWrite`. A fresh start after release gives the correct count.
- With `SCAN_LED_EN`, repeat the first scenario -> a write of 32'h3 to 32'h4000000C in the cycle after the BCD write; `done` one cycle later.

Source files
------------

// File: rtl/mem_scan_master.sv
// mem_scan_master: data-memory bus initiator that loads a word pattern into a
// local buffer, counts every (overlapping) occurrence of it in a word string,
// and writes the count to the memory-mapped BCD register.
// Optional feature macro: SCAN_LED_EN -- when defined, the result is also
// written to the LED register one cycle after the BCD write.
module mem_scan_master #(
  parameter int unsigned PAT_MAX     = 16,
  parameter logic [31:0] RESULT_ADDR = 32'h40000010,
  parameter logic [31:0] LED_ADDR    = 32'h4000000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] str_base,
  input  logic [15:0] str_len,
  input  logic [31:0] pat_base,
  input  logic [7:0]  pat_len,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] Read_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] match_count
);

  localparam int JW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, WR_RES, WR_LED, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] str_base_reg, str_base_next;
  logic [15:0] str_len_reg, str_len_next;
  logic [31:0] pat_base_reg, pat_base_next;
  logic [7:0]  pat_len_reg, pat_len_next;
  logic [15:0] i_reg, i_next;
  logic [7:0]  j_reg, j_next;
  logic [15:0] count_reg, count_next;
  logic [15:0] match_count_reg, match_count_next;
  logic [31:0] pat_buf_reg [PAT_MAX];

  logic [JW-1:0] j_idx;
  logic [16:0]   ij_sum;
  logic [15:0]   last_i;
  logic          hit;
  logic          last_j;
  logic          bad_len;

  assign j_idx   = j_reg[JW-1:0];
  // String offset plus pattern index, kept in 17 bits so it cannot wrap before scaling
  assign ij_sum  = {1'b0, i_reg} + {9'b0, j_reg};
  assign last_i  = str_len_reg - {8'b0, pat_len_reg};
  assign hit     = (Read_data == pat_buf_reg[j_idx]);
  assign last_j  = (j_reg == pat_len_reg - 8'd1);
  assign bad_len = (pat_len == 8'd0) || (32'(pat_len) > PAT_MAX) ||
                   ({8'b0, pat_len} > str_len);

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign match_count = match_count_reg;

`ifndef SCAN_LED_EN
  logic unused_led_addr;
  assign unused_led_addr = ^LED_ADDR;
`endif

  // State, latched operands, counters and published result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      str_base_reg    <= '0;
      str_len_reg     <= '0;
      pat_base_reg    <= '0;
      pat_len_reg     <= '0;
      i_reg           <= '0;
      j_reg           <= '0;
      count_reg       <= '0;
      match_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      str_base_reg    <= str_base_next;
      str_len_reg     <= str_len_next;
      pat_base_reg    <= pat_base_next;
      pat_len_reg     <= pat_len_next;
      i_reg           <= i_next;
      j_reg           <= j_next;
      count_reg       <= count_next;
      match_count_reg <= match_count_next;
    end
  end

  // Pattern buffer: captures one read word per LOAD cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(PAT_MAX); k++) pat_buf_reg[k] <= '0;
    end else if (state_reg == LOAD) begin
      pat_buf_reg[j_idx] <= Read_data;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_next       = state_reg;
    str_base_next    = str_base_reg;
    str_len_next     = str_len_reg;
    pat_base_next    = pat_base_reg;
    pat_len_next     = pat_len_reg;
    i_next           = i_reg;
    j_next           = j_reg;
    count_next       = count_reg;
    match_count_next = match_count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          str_base_next = str_base;
          str_len_next  = str_len;
          pat_base_next = pat_base;
          pat_len_next  = pat_len;
          i_next        = '0;
          j_next        = '0;
          count_next    = '0;
          state_next    = bad_len ? WR_RES : LOAD;
        end
      end
      LOAD: begin
        if (last_j) begin
          j_next     = '0;
          state_next = SCAN;
        end else begin
          j_next = j_reg + 8'd1;
        end
      end
      SCAN: begin
        if (hit && !last_j) begin
          j_next = j_reg + 8'd1;
        end else begin
          // Full match counts (saturating); any exit moves to the next offset
          if (hit && count_reg != 16'hFFFF) count_next = count_reg + 16'd1;
          j_next = '0;
          if (i_reg == last_i) state_next = WR_RES;
          else                 i_next     = i_reg + 16'd1;
        end
      end
      WR_RES: begin
`ifdef SCAN_LED_EN
        state_next = WR_LED;
`else
        state_next       = DONE;
        match_count_next = count_reg;
`endif
      end
      WR_LED: begin
`ifdef SCAN_LED_EN
        state_next       = DONE;
        match_count_next = count_reg;
`else
        state_next = IDLE;
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs decoded from registered state; idle bus is all zero
  always_comb begin
    Address    = '0;
    Write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    case (state_reg)
      LOAD: begin
        Address = pat_base_reg + {22'b0, j_reg, 2'b00};
        MemRead = 1'b1;
      end
      SCAN: begin
        Address = str_base_reg + {13'b0, ij_sum, 2'b00};
        MemRead = 1'b1;
      end
      WR_RES: begin
        Address    = RESULT_ADDR;
        Write_data = {16'b0, count_reg};
        MemWrite   = 1'b1;
      end
`ifdef SCAN_LED_EN
      WR_LED: begin
        Address    = LED_ADDR;
        Write_data = {16'b0, count_reg};
        MemWrite   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
